pad_dir_ctrl: RTL and testbench
===============================

PAD_DIR_CTRL -- requirements
Module: pad_dir_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pad bank data width.
REQ-002 SHALL have parameter TURN_CYC, default 2: dead cycles between drive and receive; legal range 1..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port tx_valid  input  1  transmit word offered.
REQ-006 SHALL have port tx_data  input  WIDTH  transmit word.
REQ-007 SHALL have port tx_ready  output  1  transmit word accepted this cycle when tx_valid=1.
REQ-008 SHALL have port rx_en  input  1  request to listen on pads.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds a sampled pad word.
REQ-010 SHALL have port rx_data  output  WIDTH  sampled pad word.
REQ-011 SHALL have port pad_a  output  WIDTH  drive data to pad cells (A).
REQ-012 SHALL have port pad_oe  output  1  pad output enable (OE).
REQ-013 SHALL have port pad_ie  output  1  pad input enable (IE).
REQ-014 SHALL have port pad_y  input  WIDTH  received data from pad cells (Y).
REQ-015 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, TX, TURN, RX; pad_oe=1 only in TX, pad_ie=1 only in RX, both registered.
REQ-017 IDLE: tx_valid=1 -> TX; else rx_en=1 -> RX; else stay; tx wins when both asserted.
REQ-018 TX: tx_ready=1; on tx_valid&tx_ready pad_a SHALL take tx_data on the next edge; tx_valid=0 -> TURN with target RX if rx_en=1, else IDLE.
REQ-019 RX: tx_valid=1 -> TURN with target TX; rx_en=0 -> TURN with target IDLE; tx_valid has priority.
REQ-020 TURN: pad_oe=0, pad_ie=0, tx_ready=0 for exactly TURN_CYC cycles, then enter latched target state; target latched on TURN entry and not changed by inputs during TURN.
REQ-021 pad_oe and pad_ie SHALL never both be 1; every TX<->RX change SHALL contain TURN_CYC cycles with both 0.
REQ-022 tx_ready SHALL be 0 outside TX; pad_a SHALL hold its last value when not updated.
REQ-023 Each RX cycle SHALL produce one rx_valid pulse with rx_data = pad_y sampled in that cycle, after fixed latency (REQ-027); rx_valid pipeline tracks pad_ie.
REQ-024 busy SHALL be 1 in TX, TURN, RX.

Reset
REQ-025 On rst_n=0 at an edge: state IDLE, pad_oe=0, pad_ie=0, tx_ready=0, rx_valid=0, pad_a=0, rx_data=0, busy=0, turn counter and sync/valid pipes cleared.
REQ-026 Reset asserted mid-TX or mid-RX SHALL drop pad_oe/pad_ie at that same edge, with no TURN phase.

Configuration
REQ-027 Macro PAD_SYNC_EN defined: pad_y passes a 2-flop synchronizer before the rx_data register; rx latency 3 cycles. Undefined: single capture register; rx latency 1 cycle.

Structure
REQ-028 Package pad_ctrl_pkg SHALL hold state encodings (2-bit) and the TURN_CYC range constant.
REQ-029 Synchronizer SHALL be sub-module pad_sync (WIDTH+1 bits, data plus valid), instantiated only under PAD_SYNC_EN.

Verification
REQ-030 Reset with tx_valid=1, rx_en=1 held -> all outputs 0 while rst_n=0; TX entered on first edge after release.
REQ-031 IDLE, tx_valid=1 with tx_data 8'hA5, 8'h3C, then 0 -> pad_a 8'hA5 then 8'h3C, pad_oe=1 for three cycles, then TURN.
REQ-032 TX ending with rx_en=1, TURN_CYC=2 -> exactly 2 cycles oe=ie=0, then pad_ie=1; pad_y=8'h5A -> rx_data=8'h5A with rx_valid after 1 cycle (3 with PAD_SYNC_EN).
REQ-033 RX active, tx_valid=1 and rx_en=0 same cycle -> TURN, then TX; rx_valid drops after pipeline drains; assertion oe&ie never 1 over 10k random cycles.
REQ-034 rst_n=0 while pad_oe=1 -> pad_oe=0 at that edge, state IDLE, no TURN.

Source files
------------

// File: rtl/pad_ctrl_pkg.sv
// Shared types and constants for the pad direction controller.
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_TURN = 2'd2,
        ST_RX   = 2'd3
    } pad_state_e;

    localparam int unsigned TURN_CYC_MIN = 1;
    localparam int unsigned TURN_CYC_MAX = 15;
    localparam int unsigned TURN_CNT_W   = $clog2(TURN_CYC_MAX + 1);

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the received pad word plus its valid flag.
module pad_sync #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pad_dir_ctrl.sv
// Bidirectional pad bank controller with a dead-time turnaround between drive and receive.
// Define PAD_SYNC_EN to route pad_y through a 2-flop synchronizer (rx latency 3 instead of 1).
module pad_dir_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_en,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic [WIDTH-1:0] pad_a,
    output logic             pad_oe,
    output logic             pad_ie,
    input  logic [WIDTH-1:0] pad_y,
    output logic             busy
);

    // Out-of-range TURN_CYC is clamped so the dead time is never zero.
    localparam int TURN_EFF = (TURN_CYC < int'(TURN_CYC_MIN)) ? int'(TURN_CYC_MIN) :
                              (TURN_CYC > int'(TURN_CYC_MAX)) ? int'(TURN_CYC_MAX) : TURN_CYC;
    localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'(TURN_EFF - 1);

    pad_state_e            state_q, state_d;
    pad_state_e            target_q, target_d;
    logic [TURN_CNT_W-1:0] cnt_q, cnt_d;
    logic                  pad_oe_q, pad_ie_q, tx_ready_q, busy_q, rx_valid_q;
    logic [WIDTH-1:0]      pad_a_q, rx_data_q;
    logic                  samp_v;
    logic [WIDTH-1:0]      samp_d;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_TX;
                end else if (rx_en) begin
                    state_d = ST_RX;
                end
            end
            ST_TX: begin
                if (!tx_valid) begin
                    state_d  = ST_TURN;
                    target_d = rx_en ? ST_RX : ST_IDLE;
                    cnt_d    = TURN_LOAD;
                end
            end
            ST_RX: begin
                if (tx_valid) begin
                    state_d  = ST_TURN;
                    target_d = ST_TX;
                    cnt_d    = TURN_LOAD;
                end else if (!rx_en) begin
                    state_d  = ST_TURN;
                    target_d = ST_IDLE;
                    cnt_d    = TURN_LOAD;
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = target_q;
                end else begin
                    cnt_d = cnt_q - TURN_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pad enables are decoded from the next state so they flip on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            target_q   <= ST_IDLE;
            cnt_q      <= '0;
            pad_oe_q   <= 1'b0;
            pad_ie_q   <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            pad_a_q    <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            pad_oe_q   <= (state_d == ST_TX);
            pad_ie_q   <= (state_d == ST_RX);
            tx_ready_q <= (state_d == ST_TX);
            busy_q     <= (state_d != ST_IDLE);
            if (tx_ready_q && tx_valid) begin
                pad_a_q <= tx_data;
            end
        end
    end

`ifdef PAD_SYNC_EN
    logic [WIDTH:0] sync_out;

    pad_sync #(
        .W (WIDTH + 1)
    ) u_pad_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({pad_ie_q, pad_y}),
        .q_o   (sync_out)
    );

    assign samp_v = sync_out[WIDTH];
    assign samp_d = sync_out[WIDTH-1:0];
`else
    assign samp_v = pad_ie_q;
    assign samp_d = pad_y;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= samp_v;
            if (samp_v) begin
                rx_data_q <= samp_d;
            end
        end
    end

    assign tx_ready = tx_ready_q;
    assign pad_oe   = pad_oe_q;
    assign pad_ie   = pad_ie_q;
    assign busy     = busy_q;
    assign pad_a    = pad_a_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_pad_dir_ctrl.sv
// Directed plus random check of pad_dir_ctrl against a cycle-level behavioural model.
module tb_pad_dir_ctrl;

    localparam int W  = 8;
    localparam int TC = 2;
`ifdef PAD_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int HMAX = 32768;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready;
    logic         rx_en;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic [W-1:0] pad_a;
    logic         pad_oe;
    logic         pad_ie;
    logic [W-1:0] pad_y;
    logic         busy;

    always #5 clk = ~clk;

    pad_dir_ctrl #(
        .WIDTH    (W),
        .TURN_CYC (TC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_en    (rx_en),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .pad_a    (pad_a),
        .pad_oe   (pad_oe),
        .pad_ie   (pad_ie),
        .pad_y    (pad_y),
        .busy     (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit verbose = 1'b1;

    // Model: which way the bank faces, how many dead cycles remain, and where it heads next.
    bit           m_drive, m_listen, m_goal_tx, m_goal_rx;
    int           m_dead;
    logic [W-1:0] m_pad_a, m_rx_data;
    bit           m_rx_valid;
    int           edge_n   = 0;
    int           last_rst = 0;
    bit           hist_v [HMAX];
    logic [W-1:0] hist_d [HMAX];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic start_turn(input bit gtx, input bit grx);
        m_drive   = 1'b0;
        m_listen  = 1'b0;
        m_goal_tx = gtx;
        m_goal_rx = grx;
        m_dead    = TC;
    endtask

    task automatic model_edge(input bit rn, input bit tv, input bit re,
                              input logic [W-1:0] td, input logic [W-1:0] py);
        int idx;
        hist_v[edge_n] = rn && m_listen;
        hist_d[edge_n] = py;
        if (!rn) begin
            m_drive = 0; m_listen = 0; m_dead = 0; m_goal_tx = 0; m_goal_rx = 0;
            m_pad_a = '0; m_rx_data = '0; m_rx_valid = 0;
            last_rst = edge_n;
        end else begin
            idx = edge_n - (LAT - 1);
            m_rx_valid = 1'b0;
            if (idx > last_rst) begin
                m_rx_valid = hist_v[idx];
            end
            if (m_rx_valid) m_rx_data = hist_d[idx];
            if (m_dead > 0) begin
                m_dead--;
                if (m_dead == 0) begin
                    m_drive  = m_goal_tx;
                    m_listen = m_goal_rx;
                end
            end else if (m_drive) begin
                if (tv) m_pad_a = td;
                else    start_turn(1'b0, re);
            end else if (m_listen) begin
                if (tv)       start_turn(1'b1, 1'b0);
                else if (!re) start_turn(1'b0, 1'b0);
            end else begin
                if (tv)      m_drive  = 1'b1;
                else if (re) m_listen = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("pad_oe",   pad_oe,   m_drive);
        chk("pad_ie",   pad_ie,   m_listen);
        chk("tx_ready", tx_ready, m_drive);
        chk("busy",     busy,     m_drive || m_listen || (m_dead > 0));
        chk("pad_a",    pad_a,    m_pad_a);
        chk("rx_valid", rx_valid, m_rx_valid);
        chk("rx_data",  rx_data,  m_rx_data);
        chk("oe_ie_excl", pad_oe & pad_ie, 1'b0);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare after settling.
    task automatic cyc(input bit rn, input bit tv, input bit re,
                       input logic [W-1:0] td, input logic [W-1:0] py);
        rst_n = rn; tx_valid = tv; rx_en = re; tx_data = td; pad_y = py;
        @(posedge clk);
        edge_n++;
        model_edge(rn, tv, re, td, py);
        #1;
        check_all();
        if (verbose)
            $display("edge %0d rst_n=%0b tx_valid=%0b rx_en=%0b tx_data=%h pad_y=%h | oe=%0b ie=%0b rdy=%0b busy=%0b pad_a=%h rx_valid=%0b rx_data=%h",
                     edge_n, rn, tv, re, td, py, pad_oe, pad_ie, tx_ready, busy, pad_a, rx_valid, rx_data);
        @(negedge clk);
    endtask

    initial begin
        bit           r_tv, r_re, r_rn;
        logic [W-1:0] r_td, r_py;

        // Reset held with both requests asserted, then release straight into TX.
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
        chk("rst_all_zero", {pad_oe, pad_ie, tx_ready, busy, rx_valid, pad_a, rx_data}, '0);
        cyc(1'b1, 1'b1, 1'b1, 8'h11, 8'h00);
        chk("rel_enters_tx", pad_oe, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("idle_not_busy", busy, 1'b0);

        // Two words transmitted, then turnaround toward receive.
        cyc(1'b1, 1'b1, 1'b0, 8'hA5, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'hA5, 8'h00);
        chk("pad_a_first", pad_a, 8'hA5);
        cyc(1'b1, 1'b1, 1'b0, 8'h3C, 8'h00);
        chk("pad_a_second", pad_a, 8'h3C);
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        chk("turn1_oe_ie", {pad_oe, pad_ie}, 2'b00);
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        chk("turn2_oe_ie", {pad_oe, pad_ie}, 2'b00);
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        chk("rx_after_turn", pad_ie, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h5A);
        repeat (LAT - 1) cyc(1'b1, 1'b0, 1'b1, 8'h00, 8'h5A);
        chk("rx_word_5a", {rx_valid, rx_data}, {1'b1, 8'h5A});

        // Receive interrupted by a transmit request: turnaround then TX.
        cyc(1'b1, 1'b1, 1'b0, 8'h77, 8'h12);
        chk("rx_to_turn", {pad_oe, pad_ie, busy}, 3'b001);
        repeat (TC) cyc(1'b1, 1'b1, 1'b0, 8'h77, 8'h34);
        chk("turn_to_tx", pad_oe, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'h99, 8'h00);
        chk("pad_a_99", pad_a, 8'h99);
        chk("rx_drained", rx_valid, 1'b0);

        // Reset while driving: enable drops at that edge, no turnaround.
        cyc(1'b0, 1'b1, 1'b1, 8'h55, 8'h00);
        chk("rst_mid_tx", {pad_oe, busy}, 2'b00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rst_no_turn", busy, 1'b0);

        // Random traffic with sticky requests and occasional resets.
        verbose = 1'b0;
        r_tv = 1'b0; r_re = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 5) == 0) r_tv = ~r_tv;
            if ($urandom_range(0, 5) == 0) r_re = ~r_re;
            r_rn = ($urandom_range(0, 299) != 0);
            r_td = W'($urandom);
            r_py = W'($urandom);
            cyc(r_rn, r_tv, r_re, r_td, r_py);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
